// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm code scheduler: emergency code numbers,
// RGB indicator patterns, the scheduler FSM states and two small helpers
// (code-to-colour map and the rotating pending-code search).
// -----------------------------------------------------------------------------
package alarm_pkg;

    // Emergency code numbers; also the bit index into req/ack/pend.
    localparam logic [1:0] CODE_RED    = 2'd0;
    localparam logic [1:0] CODE_BLUE   = 2'd1;
    localparam logic [1:0] CODE_PINK   = 2'd2;
    localparam logic [1:0] CODE_YELLOW = 2'd3;

    // Indicator patterns as {r, g, b}.
    localparam logic [2:0] RGB_RED    = 3'b100;
    localparam logic [2:0] RGB_BLUE   = 3'b001;
    localparam logic [2:0] RGB_PINK   = 3'b101;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_OFF    = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } sched_state_e;

    function automatic logic [2:0] code_to_rgb(input logic [1:0] code);
        logic [2:0] rgb;
        case (code)
            CODE_RED:    rgb = RGB_RED;
            CODE_BLUE:   rgb = RGB_BLUE;
            CODE_PINK:   rgb = RGB_PINK;
            default:     rgb = RGB_YELLOW;
        endcase
        return rgb;
    endfunction

    // Returns the first pending code found when scanning upward (mod 4) from
    // 'first'. Scanning from CODE_RED gives plain fixed priority. The result
    // is meaningless when pend is all zero; callers only use it otherwise.
    function automatic logic [1:0] pick_code(input logic [3:0] pend,
                                             input logic [1:0] first);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = first;
        // Walk from the farthest offset to the nearest so the nearest
        // pending code is the last one written and therefore wins.
        for (int k = 3; k >= 0; k--) begin
            idx = first + 2'(k);
            if (pend[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/alarm_req_sync.sv
// -----------------------------------------------------------------------------
// alarm_req_sync
// Multi-flop synchronizer for the raw, asynchronous code switches.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   d_in     in   [WIDTH-1:0] asynchronous input bits
//   d_out    out  [WIDTH-1:0] input bits after STAGES flops in clk domain
// -----------------------------------------------------------------------------
module alarm_req_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_in;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // NOTE: every stage of the chain is reset so that a switch held high
    // through reset is re-detected with the full, predictable latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment so all stages shift together on
            // the same edge instead of the input racing through the chain.
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/alarm_code_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_code_scheduler
// Latches emergency code requests until acknowledged, picks one code at a
// time, starts its announcement on the text reader, waits for completion (or
// a timeout), holds a repeat gap and then arbitrates again.
//
// Build option: define ALARM_SCHED_RR_EN for round-robin arbitration
// (search starts one past the last granted code). Without it, the lowest
// pending code index always wins (RED highest).
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   req          in   [3:0] raw code switches, bit i = code i (asynchronous)
//   ack          in   [3:0] per-code acknowledge pulses (clk domain)
//   msg_done     in   single-cycle end-of-message pulse from text reader
//   msg_start    out  single-cycle start pulse to text reader
//   msg_sel      out  [1:0] granted code, mux select
//   grant_valid  out  high while a code owns the datapath
//   rgb          out  [2:0] indicator colour of the granted code
//   pend         out  [3:0] latched pending codes
//   timeout_err  out  single-cycle pulse when msg_done never arrived
// -----------------------------------------------------------------------------
module alarm_code_scheduler
    import alarm_pkg::*;
#(
    parameter int GAP_CYCLES     = 100000000,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] ack,
    input  logic       msg_done,
    output logic       msg_start,
    output logic [1:0] msg_sel,
    output logic       grant_valid,
    output logic [2:0] rgb,
    output logic [3:0] pend,
    output logic       timeout_err
);

    // One counter serves both the message timeout and the repeat gap.
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [3:0]       req_s;
    logic [3:0]       pend_q, pend_d;
    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       search_first;
    logic [1:0]       winner;

    alarm_req_sync #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (req),
        .d_out   (req_s)
    );

    // Set wins: an ack only clears a code whose switch has been released.
    always_comb begin
        pend_d = (pend_q | req_s) & ~(ack & ~req_s);
    end

`ifdef ALARM_SCHED_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign search_first = rr_ptr_q + 2'd1;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && pend_q != 4'b0000) begin
            rr_ptr_d = winner;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= CODE_YELLOW;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign search_first = CODE_RED;
`endif

    assign winner = pick_code(pend_q, search_first);

    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        msg_start   = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q != 4'b0000) begin
                    sel_d   = winner;
                    state_d = START;
                end
            end

            START: begin
                msg_start = 1'b1;
                cnt_d     = TIMEOUT_LOAD;
                state_d   = WAIT_DONE;
            end

            WAIT_DONE: begin
                // msg_done is checked first so it beats a same-cycle timeout.
                if (msg_done) begin
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (cnt_q == '0) begin
                    timeout_err = 1'b1;
                    cnt_d       = GAP_LOAD;
                    state_d     = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= CODE_RED;
            pend_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
        end
    end

    // sel_q is only loaded on IDLE->START, so the select is stable for the
    // whole START..GAP window.
    assign grant_valid = (state_q != IDLE);
    assign msg_sel     = sel_q;
    assign rgb         = grant_valid ? code_to_rgb(sel_q) : RGB_OFF;
    assign pend        = pend_q;

endmodule
